// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: request sizes, FSM states,
// byte-lane enable patterns and the alignment / lane-steering helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Halves need an even address, words a 4-byte boundary; reserved size never passes.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~addr_lo[0];
            SZ_WORD: return (addr_lo == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    // Little-endian lane enables; only called for aligned requests.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return BE_BYTE << addr_lo;
            SZ_HALF: return BE_HALF << addr_lo;
            default: return BE_WORD;
        endcase
    endfunction

    // Right-aligned store data replicated so every enabled lane sees it.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_ext.sv
// Load extraction: picks the addressed byte/half out of a memory word and
// sign- or zero-extends it. Purely combinational so it can be shared with
// future unaligned-load work.
module load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [31:0] shifted;

    // Shift the selected lane down to bit 0, then extend by size.
    always_comb begin
        shifted = word >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            SZ_HALF: result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Multi-cycle data-memory access stage: alignment check, byte-lane steering,
// variable-latency memory handshake and load extension.
// Optional build macro DMEM_TIMEOUT_EN adds a REQ-state watchdog (MAX_WAIT cycles).
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | ready; samples req_valid, rejects misaligned requests
// ST_REQ  | mem_req held with latched fields until mem_ack (or timeout)
// ST_RESP | one-cycle rd_valid / wr_done pulse, then back to idle
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              busy,
    output logic              rd_valid,
    output logic [31:0]       rd_data,
    output logic              wr_done,
    output logic              misalign_err,
    output logic              timeout_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata
);

    state_e             state_q, state_d;
    logic               we_q, we_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic               misalign_q, misalign_d;
    logic [31:0]        ext_result;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
`endif

    load_ext u_load_ext (
        .word        (mem_rdata),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .result      (ext_result)
    );

    // Next-state and register updates for the request/response sequence.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rd_data_d  = rd_data_q;
        misalign_d = 1'b0;
`ifdef DMEM_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (is_aligned(req_size, req_addr[1:0])) begin
                        we_d    = req_we;
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        addr_d  = req_addr;
                        be_d    = lane_be(req_size, req_addr[1:0]);
                        wdata_d = lane_wdata(req_size, req_wdata);
                        state_d = ST_REQ;
`ifdef DMEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        misalign_d = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mem_ack) begin
                    if (!we_q) begin
                        rd_data_d = ext_result;
                    end
                    state_d = ST_RESP;
                end
`ifdef DMEM_TIMEOUT_EN
                // Last permitted REQ cycle without an ack: abandon the access.
                else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                    rd_data_d = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched request fields; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            rd_data_q  <= '0;
            misalign_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rd_data_q  <= rd_data_d;
            misalign_q <= misalign_d;
`ifdef DMEM_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign mem_req      = (state_q == ST_REQ);
    assign rd_valid     = (state_q == ST_RESP) & ~we_q;
    assign wr_done      = (state_q == ST_RESP) & we_q;
    assign rd_data      = rd_data_q;
    assign misalign_err = misalign_q;
    assign mem_we       = we_q;
    assign mem_addr     = addr_q[ADDR_W-1:2];
    assign mem_be       = be_q;
    assign mem_wdata    = wdata_q;

`ifdef DMEM_TIMEOUT_EN
    assign timeout_err  = timeout_q;
`else
    // Without the watchdog MAX_WAIT has no effect; keep it referenced.
    logic max_wait_unused;
    assign max_wait_unused = (MAX_WAIT != 0);
    assign timeout_err     = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit with a response scoreboard.
module tb_dmem_access_unit;
    import dmem_pkg::*;

    localparam logic [3:0] F_RD  = 4'b1000;
    localparam logic [3:0] F_WR  = 4'b0100;
    localparam logic [3:0] F_MIS = 4'b0010;
    localparam logic [3:0] F_TMO = 4'b0001;

    typedef struct packed {
        logic [3:0]  flags;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        req_valid, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        busy, rd_valid, wr_done, misalign_err, timeout_err;
    logic [31:0] rd_data;
    logic        mem_req, mem_we, mem_ack;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    dmem_access_unit #(.ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .wr_done      (wr_done),
        .misalign_err (misalign_err),
        .timeout_err  (timeout_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [3:0] flags, input logic [31:0] data);
        exp_t e;
        e.flags = flags;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; returns at the following negedge (request sampled in between).
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    // Waits (bounded) for a response pulse and scores it against the queue head.
    task automatic wait_resp(input string tag, input int budget);
        exp_t       e;
        logic [3:0] obs;
        bit         seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((rd_valid | wr_done | misalign_err | timeout_err) == 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            obs = {rd_valid, wr_done, misalign_err, timeout_err};
            chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk({tag, "_kind"}, 32'(obs), 32'(e.flags));
                if ((e.flags[3] | e.flags[0]) == 1'b1)
                    chk({tag, "_rd_data"}, rd_data, e.data);
            end
        end
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic uns, input logic [31:0] rdata, input int delay,
                           input logic [3:0] exp_be, input logic [31:0] exp_data);
        push_exp(F_RD, exp_data);
        issue(1'b0, size, uns, addr, 32'h0);
        chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        chk({tag, "_addr"}, 32'(mem_addr), addr >> 2);
        chk({tag, "_we"}, 32'(mem_we), 32'd0);
        for (int i = 0; i < delay; i++) @(negedge clk);
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk({tag, "_req_dropped"}, 32'(mem_req), 32'd0);
        wait_resp(tag, 4);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [31:0] addr, input logic [1:0] size,
                            input logic [31:0] wdata, input int delay,
                            input logic [3:0] exp_be, input logic [31:0] exp_wdata);
        int req_cycles;
        int busy_low;
        req_cycles = 0;
        busy_low   = 0;
        push_exp(F_WR, 32'h0);
        issue(1'b1, size, 1'b0, addr, wdata);
        chk({tag, "_be"}, 32'(mem_be), 32'(exp_be));
        chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        chk({tag, "_we"}, 32'(mem_we), 32'd1);
        // A competing request while busy must be ignored.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_size  = SZ_WORD;
        req_addr  = 32'h0000_0F00;
        for (int i = 0; i < delay; i++) begin
            if (mem_req) req_cycles++;
            if (!busy) busy_low++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk({tag, "_addr_stable"}, 32'(mem_addr), addr >> 2);
        if (mem_req) req_cycles++;
        if (!busy) busy_low++;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        if (!busy) busy_low++;
        chk({tag, "_req_cycles"}, 32'(req_cycles), 32'(delay + 1));
        chk({tag, "_busy_low"}, 32'(busy_low), 32'd0);
        wait_resp(tag, 4);
        @(negedge clk);
        chk({tag, "_single_done"}, 32'(wr_done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic do_misalign(input string tag, input logic [1:0] size, input logic [31:0] addr);
        push_exp(F_MIS, 32'h0);
        issue(1'b0, size, 1'b0, addr, 32'h0);
        chk({tag, "_pulse"}, 32'(misalign_err), 32'd1);
        chk({tag, "_no_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_not_busy"}, 32'(busy), 32'd0);
        wait_resp(tag, 1);
        @(negedge clk);
        chk({tag, "_pulse_end"}, 32'(misalign_err), 32'd0);
        chk({tag, "_still_no_req"}, 32'(mem_req), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = SZ_BYTE;
        req_unsigned = 1'b0;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_pulses", 32'({rd_valid, wr_done, misalign_err, timeout_err}), 32'd0);
        chk("rst_rd_data", rd_data, 32'd0);
        chk("rst_mem_fields", 32'({mem_we, mem_be}) | 32'(mem_addr) | mem_wdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Word load, ack in first REQ cycle: check latency explicitly.
        push_exp(F_RD, 32'hDEADBEEF);
        issue(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
        chk("w_ld_req", 32'(mem_req), 32'd1);
        chk("w_ld_busy", 32'(busy), 32'd1);
        chk("w_ld_addr", 32'(mem_addr), 32'h40);
        chk("w_ld_be", 32'(mem_be), 32'hF);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("w_ld_latency2", 32'(rd_valid), 32'd1);
        wait_resp("w_ld", 1);
        @(negedge clk);
        chk("w_ld_pulse_end", 32'(rd_valid), 32'd0);
        chk("w_ld_idle", 32'(busy), 32'd0);

        do_load("b_ld_s3",  32'h103, SZ_BYTE, 1'b0, 32'h80FF0011, 0, 4'b1000, 32'hFFFFFF80);
        do_load("b_ld_u3",  32'h103, SZ_BYTE, 1'b1, 32'h80FF0011, 1, 4'b1000, 32'h00000080);
        do_load("b_ld_s1",  32'h101, SZ_BYTE, 1'b0, 32'h80FF7F11, 0, 4'b0010, 32'h0000007F);
        do_load("h_ld_s2",  32'h102, SZ_HALF, 1'b0, 32'h80011234, 2, 4'b1100, 32'hFFFF8001);
        do_load("h_ld_u2",  32'h102, SZ_HALF, 1'b1, 32'h80011234, 0, 4'b1100, 32'h00008001);
        do_load("h_ld_s0",  32'h100, SZ_HALF, 1'b0, 32'h0001F234, 0, 4'b0011, 32'hFFFFF234);
        do_load("w_ld_uns", 32'h104, SZ_WORD, 1'b1, 32'h80000001, 0, 4'b1111, 32'h80000001);

        do_store("h_st", 32'h202, SZ_HALF, 32'h0000ABCD, 3, 4'b1100, 32'hABCDABCD);
        chk("rd_data_hold", rd_data, 32'h80000001);
        do_store("b_st", 32'h201, SZ_BYTE, 32'h12345677, 0, 4'b0010, 32'h77777777);
        do_store("w_st", 32'h208, SZ_WORD, 32'hCAFEF00D, 1, 4'b1111, 32'hCAFEF00D);

        do_misalign("mis_word", SZ_WORD, 32'h101);
        do_misalign("mis_rsvd", SZ_RSVD, 32'h000);
        do_misalign("mis_half", SZ_HALF, 32'h203);

        // Stray ack while idle must be ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        repeat (2) @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("idle_ack_busy", 32'(busy), 32'd0);
        chk("idle_ack_pulses", 32'({rd_valid, wr_done, misalign_err, timeout_err}), 32'd0);
        chk("idle_ack_rd_data", rd_data, 32'h80000001);

        // Reset in REQ aborts silently; next request accepted straight away.
        issue(1'b0, SZ_WORD, 1'b0, 32'h300, 32'h0);
        chk("rst_mid_req", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_req_low", 32'(mem_req), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_no_rd", 32'(rd_valid), 32'd0);
        chk("rst_mid_rd_data", rd_data, 32'd0);
        do_load("post_rst", 32'h104, SZ_WORD, 1'b0, 32'h12345678, 0, 4'b1111, 32'h12345678);

`ifdef DMEM_TIMEOUT_EN
        begin
            int req_cycles;
            req_cycles = 0;
            push_exp(F_TMO, 32'h0);
            issue(1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0);
            for (int i = 0; i < 10; i++) begin
                if (timeout_err) break;
                if (mem_req) req_cycles++;
                @(negedge clk);
            end
            chk("tmo_req_cycles", 32'(req_cycles), 32'd4);
            wait_resp("tmo", 1);
            chk("tmo_idle", 32'(busy), 32'd0);
            chk("tmo_req_low", 32'(mem_req), 32'd0);
            @(negedge clk);
            chk("tmo_pulse_end", 32'(timeout_err), 32'd0);
        end
`else
        begin
            int drops;
            drops = 0;
            push_exp(F_RD, 32'h0BADF00D);
            issue(1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0);
            for (int i = 0; i < 20; i++) begin
                if (!mem_req || timeout_err) drops++;
                @(negedge clk);
            end
            chk("no_tmo_wait", 32'(drops), 32'd0);
            mem_ack   = 1'b1;
            mem_rdata = 32'h0BADF00D;
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            wait_resp("no_tmo", 2);
            @(negedge clk);
        end
`endif

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Multi-cycle data-memory access stage directly downstream of the processor datapath's memory-access step.
- Accepts one load or store request at a time: byte, half or word; signed or unsigned loads.
- Performs the alignment check, drives byte lanes, and handshakes with a variable-latency data memory.
- Returns a sign- or zero-extended load result.
- Lets the multi-cycle controller stall on `busy` instead of assuming single-cycle memory.

Parameters:
- ADDR_W, 32, byte-address width of requests.
- MAX_WAIT, 16, cycles in REQ before timeout (used only with DMEM_TIMEOUT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request strobe; sampled only when busy=0.
- req_we  input  1  1=store, 0=load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  input  1  1=zero-extend load, 0=sign-extend.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, right-aligned.
- busy  output  1  request in flight.
- rd_valid  output  1  one-cycle pulse, load data valid.
- rd_data  output  32  extended load result.
- wr_done  output  1  one-cycle pulse, store complete.
- misalign_err  output  1  one-cycle pulse, request rejected.
- timeout_err  output  1  one-cycle pulse (DMEM_TIMEOUT_EN only; tied 0 otherwise).
- mem_req  output  1  memory request, held until mem_ack.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W-2  word address.
- mem_be  output  4  byte enables, bit i = byte lane i.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  memory completion; rdata valid same cycle.
- mem_rdata  input  32  memory read word.

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, internal registers 0. Reset mid-transaction aborts it: mem_req low after that edge, no response pulse.
- FSM states: IDLE, REQ, RESP.
- IDLE, busy=0, req_valid=1:
  - Alignment: half requires addr[0]=0; word requires addr[1:0]=00; size 11 is always rejected.
  - Misaligned request: misalign_err=1 next cycle; no memory access; stay IDLE.
  - Aligned request: latch all req_* fields; go to REQ.
- REQ: busy=1, mem_req=1; mem_we, mem_addr, mem_be, mem_wdata stable from latched fields.
  - On a cycle with mem_ack=1: capture mem_rdata and go to RESP; mem_req is 0 from the next cycle.
- RESP: busy=1.
  - Load: rd_valid=1 with rd_data extended. Store: wr_done=1.
  - Next state IDLE.
- Timing: busy rises the cycle after acceptance and is low again in the cycle after RESP. Minimum latency request→rd_valid/wr_done is 2 cycles (ack in first REQ cycle). req_valid is ignored while busy=1. rd_data holds its last value until the next load response.
- Byte lanes, little-endian:
  - be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
  - wdata: byte replicated ×4; half replicated ×2; word as-is.
- Load extraction: lane selected by addr[1:0]; the MSB of the selected byte/half is sign-extended unless req_unsigned=1. Word loads are unaffected by req_unsigned.
- A mem_ack arriving in IDLE or RESP is ignored.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined: a counter increments every REQ cycle. If it reaches MAX_WAIT without mem_ack:
  - mem_req drops;
  - timeout_err pulses for one cycle, in place of RESP;
  - rd_data is forced to 0;
  - FSM returns to IDLE.
  - The counter clears on entry to REQ.
- Undefined: no counter; REQ waits indefinitely; timeout_err tied to 0.

Decomposition:
- Package dmem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD, FSM state encodings, lane-enable constants.
- One combinational sub-module, load_ext: inputs word, addr[1:0], size, unsigned; output 32-bit result. Reused for the datapath's future LWL/LWR work.

Test Plan:
- Word load addr 0x100, mem_rdata=0xDEADBEEF, ack on 1st REQ cycle → mem_addr=0x40, mem_be=1111, rd_valid 2 cycles after request, rd_data=0xDEADBEEF.
- Signed byte load addr 0x103, mem_rdata=0x80FF0011 → mem_be=1000, rd_data=0xFFFFFF80. Same with req_unsigned=1 → 0x00000080.
- Half store addr 0x202, wdata=0x0000ABCD, ack delayed 3 cycles → mem_be=1100, mem_wdata=0xABCDABCD, mem_req held 4 cycles, wr_done once, busy high throughout.
- Word load addr 0x101 → misalign_err pulse, mem_req never asserted. Size 11 at addr 0 → misalign_err.
- reset asserted in REQ → next cycle mem_req=0, busy=0, no rd_valid; new request accepted immediately afterwards.
- DMEM_TIMEOUT_EN, MAX_WAIT=4, no ack → timeout_err after 4 REQ cycles, rd_data=0, FSM in IDLE.
